// File: rtl/hamming_serial_rx.sv
// Serial Hamming(7,4) receiver: deserializes LSB-first codewords, corrects single-bit
// errors and presents each nibble with its syndrome on a valid/ready output.
module hamming_serial_rx #(
  parameter bit          REQUIRE_SOF = 1'b1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_bit,
  input  logic             s_valid,
  input  logic             s_sof,
  output logic             s_ready,
  output logic [3:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_err,
  output logic [2:0]       m_syn,
  output logic             sof_err,
  output logic [CNT_W-1:0] corr_cnt
);

  localparam int unsigned CW_W    = 7;
  localparam int unsigned BCNT_W  = 3;

  logic [BCNT_W-1:0] bit_cnt, bit_cnt_n;
  logic [CW_W-1:0]   shift_reg, shift_n;
  logic [CW_W-1:0]   hold_reg, hold_n;
  logic              cw_full, cw_full_n;
  logic              sof_err_n;
  logic [2:0]        syn_c;
  logic [CW_W-1:0]   cw_fix_c;
  logic              load_c;

  // Syndrome and single-bit correction of the held codeword
  always_comb begin
    syn_c[0] = hold_reg[0] ^ hold_reg[2] ^ hold_reg[4] ^ hold_reg[6];
    syn_c[1] = hold_reg[1] ^ hold_reg[2] ^ hold_reg[5] ^ hold_reg[6];
    syn_c[2] = hold_reg[3] ^ hold_reg[4] ^ hold_reg[5] ^ hold_reg[6];
    cw_fix_c = hold_reg;
    if (syn_c != 3'd0) cw_fix_c[syn_c - 3'd1] = ~hold_reg[syn_c - 3'd1];
  end

  assign load_c = cw_full && (!m_valid || m_ready);

  // Bit accept / framing; accepting and loading are mutually exclusive via cw_full
  always_comb begin
    bit_cnt_n = bit_cnt;
    shift_n   = shift_reg;
    hold_n    = hold_reg;
    cw_full_n = cw_full;
    sof_err_n = 1'b0;
    if (load_c) cw_full_n = 1'b0;
    if (s_valid && !cw_full) begin
      if (s_sof) begin
        sof_err_n = (bit_cnt != 3'd0);
        shift_n   = {6'd0, s_bit};
        bit_cnt_n = 3'd1;
      end else if (bit_cnt == 3'd0) begin
        if (!REQUIRE_SOF) begin
          shift_n   = {6'd0, s_bit};
          bit_cnt_n = 3'd1;
        end
      end else begin
        for (int i = 1; i < CW_W; i++)
          if (bit_cnt == BCNT_W'(i)) shift_n[i] = s_bit;
        if (bit_cnt == BCNT_W'(CW_W - 1)) begin
          hold_n    = shift_n;
          cw_full_n = 1'b1;
          bit_cnt_n = 3'd0;
        end else begin
          bit_cnt_n = bit_cnt + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      hold_reg  <= '0;
      cw_full   <= 1'b0;
      s_ready   <= 1'b1;
      sof_err   <= 1'b0;
    end else begin
      bit_cnt   <= bit_cnt_n;
      shift_reg <= shift_n;
      hold_reg  <= hold_n;
      cw_full   <= cw_full_n;
      s_ready   <= !cw_full_n;
      sof_err   <= sof_err_n;
    end
  end

  // Output register; a load on the consume edge keeps m_valid high without a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_err    <= 1'b0;
      m_syn    <= '0;
      corr_cnt <= '0;
    end else if (load_c) begin
      m_valid <= 1'b1;
      m_data  <= {cw_fix_c[6], cw_fix_c[5], cw_fix_c[4], cw_fix_c[2]};
      m_err   <= (syn_c != 3'd0);
      m_syn   <= syn_c;
      if (syn_c != 3'd0 && corr_cnt != '1) corr_cnt <= corr_cnt + CNT_W'(1);
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: doc/hamming_serial_rx.md
Name: hamming_serial_rx

Overview:
- Receive-side counterpart of the Hamming(7,4) encode/route path.
- Deserializes a bit stream of 7-bit Hamming(7,4) codewords, sent LSB first, and corrects any single-bit error.
- Delivers each 4-bit nibble on a valid/ready output with syndrome and error status.
- Sits between the serial link and the nibble consumer (display / reassembly logic). Keeps a saturating count of corrected words.

Parameters:
- REQUIRE_SOF, 1: if 1, a bit arriving at frame position 0 without s_sof is dropped; if 0, any bit at position 0 starts a frame.
- CNT_W, 8: width of the corrected-word counter.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_bit  input  1  serial codeword bit.
- s_valid  input  1  s_bit is valid this cycle.
- s_sof  input  1  qualifies s_bit as codeword bit cw[0] (start of frame).
- s_ready  output  1  receiver can accept a bit this cycle.
- m_data  output  4  corrected nibble.
- m_valid  output  1  m_data, m_err and m_syn are valid.
- m_ready  input  1  consumer accepts the output word.
- m_err  output  1  syndrome of this word was nonzero (a correction was applied).
- m_syn  output  3  syndrome {s4,s2,s1}, i.e. the 1-based position of the error.
- sof_err  output  1  one-cycle pulse: s_sof arrived mid-frame and the partial frame was discarded.
- corr_cnt  output  CNT_W  saturating count of corrected words.

Behaviour:
- Reset (async, active-high) clears everything:
  - bit counter = 0, shift reg = 0, cw_full = 0;
  - m_valid = 0, m_data = 0, m_err = 0, m_syn = 0;
  - sof_err = 0, corr_cnt = 0.
  - s_ready = 1 after reset.
- Reset mid-frame discards partial bits and the held codeword.
- Codeword layout: cw[i] is Hamming position i+1.
  - Parity bits: cw[0]=p1, cw[1]=p2, cw[3]=p4.
  - Data bits: d[0]=cw[2], d[1]=cw[4], d[2]=cw[5], d[3]=cw[6].
- Syndrome:
  - s1 = cw[0]^cw[2]^cw[4]^cw[6]
  - s2 = cw[1]^cw[2]^cw[5]^cw[6]
  - s4 = cw[3]^cw[4]^cw[5]^cw[6]
  - If syn != 0, flip cw[syn-1] before extracting data.
  - A parity-bit error (syn = 1, 2 or 4) leaves data unchanged.
  - Double errors are miscorrected silently; no detection is required.
- Bit accept:
  - A bit is accepted when s_valid && s_ready. s_ready = !cw_full.
  - With s_sof=1, the bit is stored as cw[0] and the counter is set to 1.
  - If s_sof=1 arrives while counter != 0, sof_err pulses for one cycle and the partial frame is discarded.
  - With s_sof=0 at counter 0: dropped if REQUIRE_SOF=1, otherwise stored as cw[0].
  - With s_sof=0 at counter 1..6: the bit is stored at cw[counter] and the counter increments.
  - The bit that makes counter reach 7 copies the full codeword into the hold register: cw_full=1, counter=0.
- Decode/output stage:
  - The load condition is cw_full && (!m_valid || m_ready).
  - When it holds, on the next edge: m_data/m_err/m_syn are loaded from the decoded hold register, m_valid=1, cw_full=0.
- Latency: last bit accepted at edge t gives cw_full=1 after edge t; with no backpressure, m_valid=1 after edge t+1.
- m_valid clears on (m_valid && m_ready) only when no new word loads the same edge.
  - Simultaneous consume and load yields back-to-back valid words, with no bubble.
- Outputs are stable while m_valid && !m_ready.
- corr_cnt increments on each load with syn != 0 and saturates at all-ones; it does not wrap.
- Backpressure: while cw_full=1, s_ready=0. The upstream holds s_bit/s_valid/s_sof; no bit is lost.

Test Plan:
- Clean word: send 7'h55 LSB first with s_sof on bit 0, m_ready=1 → m_data=4'hB, m_err=0, m_syn=0, m_valid high for one cycle, 2 edges after the last bit; corr_cnt=0.
- Data error: send 7'h45 (position 5 flipped) → m_data=4'hB, m_err=1, m_syn=3'd5, corr_cnt=1.
- Parity error: send 7'h54 (position 1 flipped) → m_data=4'hB, m_syn=3'd1, m_err=1.
- Mid-frame resync: 3 bits of a frame, then s_sof with a full 7'h55 → sof_err pulses once, exactly one output word 4'hB.
- Backpressure: m_ready=0, stream three 7'h55 words → first word held, second in hold, s_ready=0 during the third; after m_ready=1, all three words delivered in order with no loss.
- Async reset asserted mid-frame and with m_valid=1 → all outputs 0 immediately; the next full frame decodes correctly. Saturation: force 2^CNT_W+3 corrected words → corr_cnt stays 8'hFF.
